// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, response entry type and address-range helper for regfile_read_port
package regfile_pkg;
    localparam int          WIDTH_DEFAULT     = 32;
    localparam int          NREGS_DEFAULT     = 4;
    localparam logic [31:0] REG1_INIT_DEFAULT = 32'h0000_0018;

    typedef struct packed {
        logic [WIDTH_DEFAULT-1:0] data;
        logic                     err;
    } rsp_entry_t;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned nregs);
        return addr < nregs;
    endfunction
endpackage

// File: rtl/regfile_rsp_fifo.sv
// regfile_rsp_fifo: 2-entry response FIFO whose head output holds the last entry once drained
module regfile_rsp_fifo
    import regfile_pkg::*;
#(
    parameter type T = rsp_entry_t
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_head,
    output logic o_full,
    output logic o_empty
);
    T           r_mem [2];
    logic       r_head;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;
    logic       w_tail;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign w_tail  = r_head ^ r_count[0];
    assign o_head  = r_mem[r_head];
    assign o_full  = r_count[1];
    assign o_empty = r_count == 2'd0;

    // The head only advances when another entry follows, so a drained FIFO keeps showing its last value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_mem[w_tail] <= i_data;
            if (w_pop && (r_count[1] || w_push)) r_head <= ~r_head;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/regfile_read_port.sv
// regfile_read_port: register storage with write port and buffered valid/ready read port; REGFILE_READ_PORT_WR_FWD_EN enables write-to-read forwarding
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int               WIDTH     = WIDTH_DEFAULT,
    parameter int               NREGS     = NREGS_DEFAULT,
    parameter int               AW        = (NREGS > 2) ? $clog2(NREGS) : 1,
    parameter logic [WIDTH-1:0] REG1_INIT = WIDTH'(REG1_INIT_DEFAULT)
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             err;
    } entry_t;

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] w_rd_data;
    logic             w_req_in;
    logic             w_wr_in;
    logic             w_fwd;
    logic             w_full;
    logic             w_empty;
    entry_t           w_push_entry;
    entry_t           w_head;

    assign w_req_in = addr_in_range(32'(req_addr), NREGS);
    assign w_wr_in  = addr_in_range(32'(wr_addr), NREGS);

`ifdef REGFILE_READ_PORT_WR_FWD_EN
    assign w_fwd = wr_en && w_wr_in && (wr_addr == req_addr);
`else
    assign w_fwd = 1'b0;
`endif

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NREGS; k++) w_rd_data = (int'(req_addr) == k) ? r_regs[k] : w_rd_data;
    end

    assign w_push_entry.data = !w_req_in ? '0 : w_fwd ? wr_data : w_rd_data;
    assign w_push_entry.err  = !w_req_in;

    // Out-of-range write addresses match no slot and are dropped
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            for (int k = 0; k < NREGS; k++) r_regs[k] <= (k == 1) ? REG1_INIT : '0;
        end else begin
            for (int k = 0; k < NREGS; k++) if (wr_en && int'(wr_addr) == k) r_regs[k] <= wr_data;
        end
    end

    regfile_rsp_fifo #(.T(entry_t)) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (ASYNCRESETN),
        .i_push  (req_valid),
        .i_data  (w_push_entry),
        .i_pop   (rsp_ready),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign req_ready = !w_full;
    assign rsp_valid = !w_empty;
    assign rsp_data  = w_head.data;
    assign rsp_err   = w_head.err;
endmodule

// File: tb/tb_regfile_read_port.sv
// tb_regfile_read_port: directed vector table, reset sequence and queue-model random check of regfile_read_port
module tb_regfile_read_port;
    localparam int WIDTH = 32;
    localparam int NREGS = 4;
    localparam int AW    = 3;
`ifdef REGFILE_READ_PORT_WR_FWD_EN
    localparam logic [31:0] SAME_CYCLE_RD = 32'h1234_5678;
    localparam bit          FWD           = 1'b1;
`else
    localparam logic [31:0] SAME_CYCLE_RD = 32'h0000_0000;
    localparam bit          FWD           = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          ASYNCRESETN = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_data;
    logic          rsp_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    regfile_read_port #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err)
    );

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic        rv;
        logic [2:0]  ra;
        logic        rr;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
        logic        ery;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } ent_t;

    vec_t        tbl [19];
    logic [31:0] m_regs [NREGS];
    ent_t        q [$];
    logic [31:0] last_d;
    logic        last_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                         input logic rv, input logic [2:0] ra, input logic rr);
        wr_en = we; wr_addr = wa; wr_data = wd;
        req_valid = rv; req_addr = ra; rsp_ready = rr;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic [31:0] ed,
                                 input logic ee, input logic ery);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'(ev));
        chk({tag, "_ready"}, 32'(req_ready), 32'(ery));
        chk({tag, "_data"}, rsp_data, ed);
        chk({tag, "_err"}, 32'(rsp_err), 32'(ee));
    endtask

    task automatic do_reset();
        wr_en = 0; req_valid = 0; rsp_ready = 0;
        @(negedge CLK);
        ASYNCRESETN = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        ASYNCRESETN = 1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //            we  wa  wd             rv  ra  rr   ev  ed             ee  ery
        tbl[0]  = '{0, 0, 32'h0,          1, 1, 1,   1, 32'h18,         0, 1};
        tbl[1]  = '{0, 0, 32'h0,          1, 0, 1,   1, 32'h0,          0, 1};
        tbl[2]  = '{1, 2, 32'hDEADBEEF,   0, 0, 1,   0, 32'h0,          0, 1};
        tbl[3]  = '{0, 0, 32'h0,          1, 2, 1,   1, 32'hDEADBEEF,   0, 1};
        tbl[4]  = '{1, 3, 32'h12345678,   1, 3, 1,   1, SAME_CYCLE_RD,  0, 1};
        tbl[5]  = '{0, 0, 32'h0,          1, 3, 1,   1, 32'h12345678,   0, 1};
        tbl[6]  = '{0, 0, 32'h0,          1, 5, 1,   1, 32'h0,          1, 1};
        tbl[7]  = '{1, 5, 32'hFFFFFFFF,   0, 0, 1,   0, 32'h0,          1, 1};
        tbl[8]  = '{0, 0, 32'h0,          1, 0, 0,   1, 32'h0,          0, 1};
        tbl[9]  = '{0, 0, 32'h0,          1, 1, 0,   1, 32'h0,          0, 0};
        tbl[10] = '{0, 0, 32'h0,          1, 2, 0,   1, 32'h0,          0, 0};
        tbl[11] = '{0, 0, 32'h0,          1, 2, 1,   1, 32'h18,         0, 1};
        tbl[12] = '{0, 0, 32'h0,          1, 2, 1,   1, 32'hDEADBEEF,   0, 1};
        tbl[13] = '{0, 0, 32'h0,          0, 0, 1,   0, 32'hDEADBEEF,   0, 1};
        tbl[14] = '{0, 0, 32'h0,          1, 0, 1,   1, 32'h0,          0, 1};
        tbl[15] = '{0, 0, 32'h0,          1, 1, 1,   1, 32'h18,         0, 1};
        tbl[16] = '{0, 0, 32'h0,          1, 2, 1,   1, 32'hDEADBEEF,   0, 1};
        tbl[17] = '{0, 0, 32'h0,          1, 3, 1,   1, 32'h12345678,   0, 1};
        tbl[18] = '{0, 0, 32'h0,          0, 0, 1,   0, 32'h12345678,   0, 1};

        repeat (3) @(posedge CLK);
        #1;
        check_outputs("in_reset", 0, 32'h0, 0, 1);
        @(negedge CLK);
        ASYNCRESETN = 1;
        @(posedge CLK);
        #1;
        check_outputs("after_reset", 0, 32'h0, 0, 1);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra, tbl[i].rr);
            check_outputs($sformatf("v%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ee, tbl[i].ery);
        end

        // Full buffer then asynchronous reset in the middle of a cycle
        drive(1, 1, 32'hAAAA5555, 0, 0, 1);
        drive(0, 0, 32'h0, 1, 0, 0);
        drive(0, 0, 32'h0, 1, 2, 0);
        check_outputs("full", 1, 32'h0, 0, 0);
        wr_en = 0; req_valid = 0; rsp_ready = 0;
        @(negedge CLK);
        #2 ASYNCRESETN = 0;
        #1;
        check_outputs("mid_reset", 0, 32'h0, 0, 1);
        @(negedge CLK);
        ASYNCRESETN = 1;
        @(posedge CLK);
        #1;
        chk("post_reset_ready", 32'(req_ready), 32'h1);
        drive(0, 0, 32'h0, 1, 1, 1);
        check_outputs("post_reset_reg1", 1, 32'h18, 0, 1);

        // Randomised traffic against a queue model
        do_reset();
        for (int k = 0; k < NREGS; k++) m_regs[k] = (k == 1) ? 32'h18 : 32'h0;
        q.delete();
        last_d = 0;
        last_e = 0;
        begin
            logic       pend;
            logic       rv;
            logic [2:0] ra;
            pend = 0;
            rv = 0;
            ra = 0;
            for (int c = 0; c < 3000; c++) begin
                logic        we, rr, acc, pp;
                logic [2:0]  wa;
                logic [31:0] wd;
                ent_t        e;
                if (!pend) begin
                    rv = ($urandom_range(0, 3) != 0);
                    ra = 3'($urandom_range(0, 7));
                end
                we = $urandom_range(0, 1) == 1;
                wa = ($urandom_range(0, 2) == 0) ? ra : 3'($urandom_range(0, 7));
                wd = $urandom;
                rr = $urandom_range(0, 2) != 0;
                acc = rv && (q.size() < 2);
                pp = rr && (q.size() > 0);
                e.e = !(ra < NREGS);
                e.d = e.e ? 32'h0 : (FWD && we && wa == ra) ? wd : m_regs[ra];
                drive(we, wa, wd, rv, ra, rr);
                if (pp) void'(q.pop_front());
                if (acc) q.push_back(e);
                if (we && wa < NREGS) m_regs[wa] = wd;
                if (q.size() > 0) begin
                    last_d = q[0].d;
                    last_e = q[0].e;
                end
                pend = rv && !acc;
                check_outputs($sformatf("rnd%0d", c), q.size() > 0, last_d, last_e, q.size() < 2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Read side of the 32-bit register-file block. It owns NREGS storage registers with a simple write port. It serves read requests over a valid/ready request channel and returns data over a valid/ready response channel.
- A 2-entry response buffer decouples a stalled consumer from the request side.
- Sits between the register-file write logic and any datapath consumer that reads registers with backpressure.

Parameters:
- WIDTH, 32, data width of each register and of the read data.
- NREGS, 4, number of registers; address width AW = clog2(NREGS), minimum 1.
- REG1_INIT, 32'h00000018, reset/init value of register 1. All other registers reset to 0.

Ports:
- CLK  input  1  clock, rising edge.
- ASYNCRESETN  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe.
- wr_addr  input  AW  write address.
- wr_data  input  WIDTH  write data.
- req_valid  input  1  read request valid.
- req_ready  output  1  read request accepted when high together with req_valid.
- req_addr  input  AW  read address.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  WIDTH  read data.
- rsp_err  output  1  address was out of range (addr >= NREGS).

Behaviour:
- Reset (ASYNCRESETN low, asynchronous assert, synchronous deassert by the driver):
  - reg[1] = REG1_INIT; all other reg[i] = 0.
  - Buffer count = 0; rsp_valid = 0; rsp_data = 0; rsp_err = 0.
  - req_ready = 1 as soon as reset is released.
- Write port:
  - On a rising edge with wr_en = 1 and wr_addr < NREGS, reg[wr_addr] takes wr_data.
  - A write with wr_addr >= NREGS is ignored.
  - Takes effect 1 cycle after the edge.
- Request accept (push) occurs when req_valid & req_ready at the edge.
  - Read data is the storage value before this edge's write (read-before-write), except as modified by the optional feature.
  - Out-of-range addresses push data 0 with err = 1.
- Latency: a request accepted at edge N appears on rsp_valid/rsp_data/rsp_err right after edge N when the buffer was empty (1-cycle latency). There is no combinational path from req to rsp.
- Response buffer is a 2-entry FIFO; rsp_* shows the head entry.
  - Pop occurs when rsp_valid & rsp_ready.
  - req_ready = (count < 2). It is registered-state based and has no combinational dependence on rsp_ready.
  - Push and pop in the same cycle: count unchanged and order preserved.
  - Full (count = 2): req_ready = 0 and requests stall; the requester must hold req_addr stable.
  - Empty: rsp_valid = 0, and rsp_data/rsp_err hold their last values.
- Order is strictly FIFO. No request is dropped or duplicated.
- Reset mid-operation discards buffered responses immediately. Storage returns to init values.

Optional Feature:
- Macro: REGFILE_READ_PORT_WR_FWD_EN.
- Defined: if wr_en and wr_addr == req_addr (in range) at the accept edge, the pushed data is wr_data (write-to-read forwarding).
- Undefined: the pushed data is the old register value (read-before-write).
- Storage behaviour is identical in both builds.

Decomposition:
- Package regfile_pkg holds:
  - WIDTH_DEFAULT, NREGS_DEFAULT, REG1_INIT_DEFAULT.
  - A typedef rsp_entry_t {data[WIDTH], err}.
  - A helper function for address-range check.
- One sub-module: regfile_rsp_fifo, the 2-entry FIFO of rsp_entry_t with count, push/pop, and full/empty.
- Storage and write logic stay in the top.

Test Plan:
- Reset then read addr 1, addr 0 with rsp_ready=1 -> responses 0x00000018, 0x00000000, each 1 cycle after accept.
- Write 0xDEADBEEF to addr 2, read addr 2 on the next cycle -> rsp_data=0xDEADBEEF, rsp_err=0.
- Same-cycle write 0x12345678 to addr 3 and read addr 3 -> old value 0 without the macro; 0x12345678 with REGFILE_READ_PORT_WR_FWD_EN.
- Hold rsp_ready=0 and issue 3 back-to-back reads (addr 0,1,2) -> req_ready drops after 2 accepts. Then raise rsp_ready -> responses arrive in order 0, 0x18, reg2, with no loss.
- Read addr 5 with NREGS=4 (AW=3 build) -> rsp_data=0, rsp_err=1. A write to addr 5 leaves all registers unchanged.
- Fill the buffer, then pulse ASYNCRESETN low mid-cycle -> rsp_valid=0 immediately, req_ready=1 after release, reg1 reads 0x18.
